// File: rtl/deparser_pkg.sv
// Shared constants and state codes for the deparser (header write-back engine).
// Optional read-back verification is enabled by defining DEPARSER_VERIFY_EN.
`timescale 1ns/1ps
package deparser_pkg;
  localparam int NUM_HEADERS = 4;
  localparam int WORD_WIDTH  = 32;
  localparam int ADDR_BUS    = 32;
  localparam int DATA_BUS    = 32;
  localparam int HDR_BYTES   = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    DPS_IDLE   = 2'd0,
    DPS_WRITE  = 2'd1,
    DPS_VERIFY = 2'd2,
    DPS_DONE   = 2'd3
  } dps_state_t;
endpackage

// File: rtl/deparser_next_set_bit.sv
// Combinational finder: lowest set bit of mask strictly above from_idx.
// from_idx is signed so that -1 means "search from bit 0".
`timescale 1ns/1ps
module deparser_next_set_bit #(
  parameter int NUM_HDRS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [NUM_HDRS-1:0] mask,
  input  logic signed [IDX_W:0] from_idx,
  output logic [IDX_W-1:0]    idx,
  output logic                found
);
  logic [NUM_HDRS-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_HDRS; gi++) begin : g_hit
      assign hit[gi] = mask[gi] && (gi > int'(from_idx));
    end
  endgenerate

  // Scan downward so the lowest qualifying bit is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_HDRS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/deparser.sv
// Writes the valid header words back to packet SRAM as a contiguous run from base_addr_i.
// Define DEPARSER_VERIFY_EN to add a read-back cycle after each write and a sticky err_o.
`timescale 1ns/1ps
module deparser
  import deparser_pkg::*;
#(
  parameter int NUM_HDRS = NUM_HEADERS,
  parameter int WORD_W   = WORD_WIDTH,
  parameter int BYTES_W  = HDR_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [WORD_W*NUM_HDRS-1:0] hdrs_i,
  input  logic [NUM_HDRS-1:0]        hdr_valid_i,
  input  logic [ADDR_BUS-1:0]        base_addr_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       mem_ce_o,
  output logic                       mem_we_o,
  output logic [ADDR_BUS-1:0]        mem_addr_o,
  output logic [3:0]                 mem_width_o,
  output logic [DATA_BUS-1:0]        mem_data_o,
  input  logic [DATA_BUS-1:0]        mem_data_i
);
  localparam int IDX_W = (NUM_HDRS > 1) ? $clog2(NUM_HDRS) : 1;
  localparam logic [ADDR_BUS-1:0] STEP = ADDR_BUS'(BYTES_W);

  dps_state_t                 state_reg;
  logic [WORD_W*NUM_HDRS-1:0] hdrs_reg;
  logic [NUM_HDRS-1:0]        mask_reg;
  logic [ADDR_BUS-1:0]        ptr_reg;
  logic [IDX_W-1:0]           idx_reg;
  logic [IDX_W-1:0]           first_idx;
  logic [IDX_W-1:0]           next_idx;
  logic                       first_found;
  logic                       next_found;

  deparser_next_set_bit #(.NUM_HDRS(NUM_HDRS), .IDX_W(IDX_W)) u_first (
    .mask     (hdr_valid_i),
    .from_idx ({(IDX_W+1){1'b1}}),
    .idx      (first_idx),
    .found    (first_found)
  );

  deparser_next_set_bit #(.NUM_HDRS(NUM_HDRS), .IDX_W(IDX_W)) u_next (
    .mask     (mask_reg),
    .from_idx ({1'b0, idx_reg}),
    .idx      (next_idx),
    .found    (next_found)
  );

  assign mem_width_o = 4'(BYTES_W);

`ifdef DEPARSER_VERIFY_EN
  logic err_reg;
  assign err_o = err_reg;
`else
  logic unused_mem_data;
  assign err_o           = FALSE;
  assign unused_mem_data = ^mem_data_i;
`endif

  // The first write is issued on the start edge itself, so ptr_reg always holds
  // the address of the *next* word to be written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= DPS_IDLE;
      hdrs_reg   <= '0;
      mask_reg   <= '0;
      ptr_reg    <= '0;
      idx_reg    <= '0;
      busy_o     <= FALSE;
      done_o     <= FALSE;
      mem_ce_o   <= FALSE;
      mem_we_o   <= FALSE;
      mem_addr_o <= '0;
      mem_data_o <= '0;
`ifdef DEPARSER_VERIFY_EN
      err_reg    <= FALSE;
`endif
    end else begin
      done_o <= FALSE;
      case (state_reg)
        DPS_IDLE: begin
          if (start_i) begin
            hdrs_reg <= hdrs_i;
            mask_reg <= hdr_valid_i;
`ifdef DEPARSER_VERIFY_EN
            err_reg  <= FALSE;
`endif
            if (first_found) begin
              state_reg  <= DPS_WRITE;
              busy_o     <= TRUE;
              mem_ce_o   <= TRUE;
              mem_we_o   <= TRUE;
              mem_addr_o <= base_addr_i;
              mem_data_o <= hdrs_i[first_idx*WORD_W +: WORD_W];
              ptr_reg    <= base_addr_i + STEP;
              idx_reg    <= first_idx;
            end else begin
              state_reg <= DPS_DONE;
              done_o    <= TRUE;
            end
          end
        end
`ifdef DEPARSER_VERIFY_EN
        DPS_WRITE: begin
          state_reg <= DPS_VERIFY;
          mem_we_o  <= FALSE;
        end
        DPS_VERIFY: begin
          if (mem_data_i != mem_data_o) err_reg <= TRUE;
`else
        DPS_WRITE: begin
`endif
          if (next_found) begin
            state_reg  <= DPS_WRITE;
            mem_we_o   <= TRUE;
            mem_addr_o <= ptr_reg;
            mem_data_o <= hdrs_reg[next_idx*WORD_W +: WORD_W];
            ptr_reg    <= ptr_reg + STEP;
            idx_reg    <= next_idx;
          end else begin
            state_reg <= DPS_DONE;
            mem_ce_o  <= FALSE;
            mem_we_o  <= FALSE;
            busy_o    <= FALSE;
            done_o    <= TRUE;
          end
        end
        DPS_DONE: state_reg <= DPS_IDLE;
        default:  state_reg <= DPS_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_deparser.sv
// Scoreboard bench for deparser: expected SRAM accesses are queued at stimulus time
// and matched against the memory bus; a behavioural SRAM holds the written image.
`timescale 1ns/1ps
module tb_deparser;
  import deparser_pkg::*;

  localparam int N  = NUM_HEADERS;
  localparam int HW = WORD_WIDTH * NUM_HEADERS;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start_i = 1'b0;
  logic [HW-1:0]       hdrs_i = '0;
  logic [N-1:0]        hdr_valid_i = '0;
  logic [ADDR_BUS-1:0] base_addr_i = '0;
  logic                busy_o, done_o, err_o, mem_ce_o, mem_we_o;
  logic [ADDR_BUS-1:0] mem_addr_o;
  logic [3:0]          mem_width_o;
  logic [DATA_BUS-1:0] mem_data_o, mem_data_i;

  logic        init_mem = 1'b1;
  logic        corrupt  = 1'b0;
  logic [31:0] sram    [0:63];
  logic [31:0] exp_mem [0:63];
  txn_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  deparser dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .hdrs_i      (hdrs_i),
    .hdr_valid_i (hdr_valid_i),
    .base_addr_i (base_addr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .mem_ce_o    (mem_ce_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_width_o (mem_width_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) sram[i] <= 32'hDEAD_0000 + i;
    end else if (!rst && mem_ce_o && mem_we_o) begin
      sram[mem_addr_o[7:2]] <= mem_data_o;
    end
  end

  assign mem_data_i = sram[mem_addr_o[7:2]] ^ (corrupt ? 32'h0000_0001 : 32'h0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int k);
`ifdef DEPARSER_VERIFY_EN
    return 2 * k + 1;
`else
    return k + 1;
`endif
  endfunction

  // Bus monitor: every enabled cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && mem_ce_o) begin
      txn_t e;
      $display("txn %s addr=%h data=%h", mem_we_o ? "WR" : "RD", mem_addr_o, mem_data_o);
      if (sb.size() == 0) begin
        check("unexpected_access_sb_size", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("bus_we", mem_we_o, e.we);
        check("bus_addr", mem_addr_o, e.addr);
        check("bus_data", mem_data_o, e.data);
        check("bus_width", mem_width_o, 32'd4);
      end
    end
  end

  task automatic push_op(input logic [N-1:0] mask, input logic [31:0] base,
                         input logic [HW-1:0] hdrs, output int k);
    logic [31:0] p;
    logic [31:0] d;
    p = base;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        d = hdrs[i*32 +: 32];
        sb.push_back(txn_t'{1'b1, p, d});
`ifdef DEPARSER_VERIFY_EN
        sb.push_back(txn_t'{1'b0, p, d});
`endif
        exp_mem[p[7:2]] = d;
        p = p + 32'd4;
        k++;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [N-1:0] mask,
                        input logic [31:0] base, input logic [HW-1:0] hdrs);
    int k;
    bit seen;
    @(negedge clk);
    hdrs_i = hdrs;
    hdr_valid_i = mask;
    base_addr_i = base;
    start_i = 1'b1;
    push_op(mask, base, hdrs, k);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    hdrs_i = ~hdrs;
    hdr_valid_i = ~mask;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 2 * k + 4 && !seen; cyc++) begin
      @(negedge clk);
      if (done_o) begin
        check({name, "_done_cycle"}, cyc, lat(k));
        check({name, "_busy_at_done"}, busy_o, 1'b0);
        seen = 1'b1;
      end else begin
        check({name, "_busy"}, busy_o, (k > 0) ? 1'b1 : 1'b0);
      end
    end
    if (!seen) check({name, "_done_timeout"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({name, "_done_pulse_width"}, done_o, 1'b0);
    check({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int ka, kb, ndone, d1, d2, nv;
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'hDEAD_0000 + i;

    #25;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_ce", mem_ce_o, 1'b0);
    check("rst_we", mem_we_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_data", mem_data_o, 32'd0);
    check("rst_width", mem_width_o, 32'd4);
    #20;
    rst = 1'b0;
    init_mem = 1'b0;

    run_op("all_valid", 4'b1111, 32'd0, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
    check("all_valid_err", err_o, 1'b0);
    run_op("sparse", 4'b1010, 32'd16, {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A});
    run_op("empty_mask", 4'b0000, 32'd40, {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444});
    run_op("single_top", 4'b1000, 32'd96, {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000});
    run_op("addr_wrap", 4'b0011, 32'hFFFF_FFFC, {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000});

    // Reset in the middle of a four-word run.
    @(negedge clk);
    hdrs_i = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
    hdr_valid_i = 4'b1111;
    base_addr_i = 32'd64;
    start_i = 1'b1;
    sb.push_back(txn_t'{1'b1, 32'd64, 32'hC000_0000});
`ifdef DEPARSER_VERIFY_EN
    sb.push_back(txn_t'{1'b0, 32'd64, 32'hC000_0000});
    nv = 3;
`else
    nv = 2;
`endif
    sb.push_back(txn_t'{1'b1, 32'd68, 32'hC000_0001});
    exp_mem[16] = 32'hC000_0000;
    exp_mem[17] = 32'hC000_0001;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (nv) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ce_async", mem_ce_o, 1'b0);
    check("midrst_busy_async", busy_o, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_done", done_o, 1'b0);
    end
    #5;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_ce", mem_ce_o, 1'b0);
    check("midrst_idle_done", done_o, 1'b0);
    check("midrst_sb_drained", 32'(sb.size()), 32'd0);

    // start_i held through completion: exactly two back-to-back operations.
    @(negedge clk);
    hdrs_i = {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000};
    hdr_valid_i = 4'b0011;
    base_addr_i = 32'd128;
    start_i = 1'b1;
    push_op(4'b0011, 32'd128, {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000}, ka);
    push_op(4'b0101, 32'd160, {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000}, kb);
    @(posedge clk);
    #1;
    hdrs_i = {32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000};
    hdr_valid_i = 4'b0101;
    base_addr_i = 32'd160;
    ndone = 0;
    d1 = 0;
    d2 = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (done_o) begin
        ndone++;
        if (ndone == 1) d1 = cyc;
        else if (ndone == 2) begin
          d2 = cyc;
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    check("held_start_done_count", ndone, 32'd2);
    check("held_start_first_done", d1, lat(ka));
    check("held_start_second_done", d2, lat(ka) + 1 + lat(kb));
    check("held_start_sb_drained", 32'(sb.size()), 32'd0);

`ifdef DEPARSER_VERIFY_EN
    corrupt = 1'b1;
    run_op("verify_bad", 4'b0110, 32'd192, {32'h9000_0003, 32'h9000_0002, 32'h9000_0001, 32'h9000_0000});
    corrupt = 1'b0;
    check("verify_err_set", err_o, 1'b1);
    repeat (3) @(negedge clk);
    check("verify_err_sticky", err_o, 1'b1);
    run_op("verify_good", 4'b1001, 32'd208, {32'h9100_0003, 32'h9100_0002, 32'h9100_0001, 32'h9100_0000});
    check("verify_err_cleared", err_o, 1'b0);
`endif

    for (int i = 0; i < 64; i++) check($sformatf("sram_word_%0d", i), sram[i], exp_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
